// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - SW/SB store buffer draining big-endian lanes to the data-cache write port
// Formats stores into 4-byte lanes with byte enables, queues them FIFO, flags load/store word hazards.
module store_buffer_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic                   is_LB_SB,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [1:0]             mem_block,
  input  logic [31:0]            st_data,
  output logic                   misaligned,
  output logic                   cache_we,
  input  logic                   cache_ready,
  output logic [ADDR_W-1:0]      cache_addr,
  output logic [0:3][7:0]        cache_data_in,
  output logic [3:0]             cache_byte_en,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_conflict,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misaligned_q, misaligned_d;
  logic [ADDR_W-3:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic              full, sw_misaligned, enq, deq, ld_hit;
  logic [31:0]       new_data;
  logic [3:0]        new_be;
  logic              unused_ld_offset;

  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign st_ready      = !full;
  assign count         = count_q;
  assign misaligned    = misaligned_q;
  assign sw_misaligned = !is_LB_SB && (st_addr[1:0] != 2'b00);
  assign enq           = st_valid && !full && !sw_misaligned;
  assign deq           = !empty && cache_ready;
  assign unused_ld_offset = ^ld_addr[1:0];

  // SB replicates its byte into every lane; the enable picks the live one
  always_comb begin
    new_data = st_data;
    new_be   = 4'b1111;
    if (is_LB_SB) begin
      new_data = {4{st_data[7:0]}};
      new_be   = 4'b0001 << mem_block;
    end
  end

  always_comb begin
    wr_ptr_d     = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    misaligned_d = st_valid && sw_misaligned;
    count_d      = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      if (deq) valid_q[rd_ptr_q] <= 1'b0;
      if (enq) begin
        valid_q[wr_ptr_q] <= 1'b1;
        addr_q[wr_ptr_q]  <= st_addr[ADDR_W-1:2];
        data_q[wr_ptr_q]  <= new_data;
        be_q[wr_ptr_q]    <= new_be;
      end
    end
  end

  assign cache_we      = !empty;
  assign cache_addr    = empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
  assign cache_data_in = empty ? '0 : data_q[rd_ptr_q];
  assign cache_byte_en = empty ? '0 : be_q[rd_ptr_q];

  // Hazard covers buffered entries and the store being accepted this cycle
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr[ADDR_W-1:2])) ld_hit = 1'b1;
    end
    if (enq && (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) ld_hit = 1'b1;
    ld_conflict = ld_valid && ld_hit;
  end

endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Write-side counterpart of the load/writeback data path.
- Accepts SW/SB stores from the MEM stage and formats them into the 4-byte big-endian cache lane layout, with byte enables.
- Buffers stores in a small FIFO and drains them to the data-cache write port over a valid/ready handshake.
- Flags loads that hit a pending store so the pipeline can stall them until the store retires.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_ready  out  1  buffer can accept a store; equals !full.
- is_LB_SB  in  1  1 = byte store (SB), 0 = word store (SW).
- st_addr  in  ADDR_W  store byte address.
- mem_block  in  2  byte lane for SB; ignored for SW.
- st_data  in  32  store data; SB uses [7:0].
- misaligned  out  1  one-cycle pulse when an SW with st_addr[1:0]!=0 is presented.
- cache_we  out  1  head entry valid at the cache port.
- cache_ready  in  1  cache accepts the head entry this cycle.
- cache_addr  out  ADDR_W  word-aligned head address; bits [1:0] are 0.
- cache_data_in  out  8 x [0:3]  head data bytes; index 0 = bits [31:24].
- cache_byte_en  out  4  bit i enables cache_data_in[i].
- ld_valid  in  1  a load is in MEM this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_conflict  out  1  load word address matches a buffered or incoming store.
- empty  out  1  no buffered stores.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst high at posedge):
  - Read/write pointers and count go to 0; all entries are invalidated.
  - Outputs after reset: st_ready=1, empty=1, cache_we=0, misaligned=0, cache_byte_en=0, cache_addr=0, cache_data_in all 0, ld_conflict=0, count=0.
  - Reset asserted mid-drain discards all pending stores; none are retried.
- Enqueue: occurs when st_valid && st_ready && !(SW && st_addr[1:0]!=0). Each entry holds:
  - Word address: st_addr[ADDR_W-1:2].
  - SW: bytes {st_data[31:24], st_data[23:16], st_data[15:8], st_data[7:0]} into lanes 0..3; byte_en=4'b1111.
  - SB: st_data[7:0] written to every lane; byte_en one-hot at bit mem_block (mem_block=2 gives 4'b0100).
- Misaligned SW:
  - The store is not enqueued.
  - misaligned is registered: it is high the cycle after the offending presentation, for one cycle.
  - st_ready is unaffected.
- Dequeue:
  - cache_we = !empty; head fields are driven from the FIFO registers.
  - The head retires on the posedge where cache_we && cache_ready.
  - Head outputs are stable while cache_we=1 and cache_ready=0.
  - When empty, cache_data_in and cache_byte_en are 0.
- Latency: a store accepted at edge N appears at the cache port in cycle N+1. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged.
  - When full, st_ready=0 even if the head retires that cycle; the freed slot is offered on the next cycle.
  - st_ready has no combinational path from cache_ready.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- ld_conflict (combinational) = ld_valid && any of:
  - a valid entry's word address equals ld_addr[ADDR_W-1:2];
  - an incoming accepted store this cycle has the same word address.
- Ordering: strict FIFO; entries are never merged or coalesced.

Test Plan:
- Reset, then SW of 0xDEADBEEF to 0x100 with cache_ready=1: next cycle cache_we=1, cache_addr=0x100, bytes DE,AD,BE,EF, byte_en=1111; following cycle empty=1.
- SB of st_data=0x000000A5, st_addr=0x206, mem_block=2: cache_addr=0x204, byte_en=0100, lane 2=A5.
- Hold cache_ready=0 and issue 4 SWs to 0x0, 0x4, 0x8, 0xC:
  - count=4, st_ready=0, and a 5th store is not accepted.
  - Raise cache_ready: retire order is 0x0, 0x4, 0x8, 0xC; st_ready returns one cycle after the first retire.
- SW to 0x102:
  - Not enqueued; misaligned pulses one cycle; count stays 0.
  - Back-to-back enqueue/dequeue at count=2 holds count at 2.
- With an SW to 0x40 buffered: a load to 0x43 gives ld_conflict=1, a load to 0x44 gives 0; conflict clears the cycle after retire.
  - A load to 0x80 in the same cycle as an accepted SB to 0x81 gives ld_conflict=1.
- Assert rst with 3 pending stores during drain: next cycle count=0, cache_we=0, st_ready=1; no further cache writes occur.
